// File: rtl/uart_loader_if.sv
// Bus-initiator handshake signals for uart_loader; the 32-bit data lane stays a
// plain inout port on the loader because it is shared tristate with responders.
interface uart_loader_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;

  modport master (output mem_req, output mem_we, output mem_addr);
  modport slave  (input  mem_req, input  mem_we, input  mem_addr);
endinterface

// File: rtl/uart_loader.sv
// uart_loader: host UART (8N1) command bridge issuing single 32-bit bus reads/writes.
// Define UART_LOADER_TIMEOUT_EN to abandon partial frames after an inter-byte timeout.
module uart_loader #(
  parameter int BAUD_DIV     = 434,
  parameter int TIMEOUT_BITS = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          uart_rx,
  output logic          uart_tx,
  output logic          busy,
  uart_loader_if.master bus,
  inout  wire  [31:0]   mem_data
);

  localparam int               CNT_W     = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BAUD_DIV / 2 - 1);
  localparam logic [7:0]       CMD_WRITE = 8'hA5;
  localparam logic [7:0]       CMD_READ  = 8'h5A;
  localparam logic [7:0]       ACK_BYTE  = 8'h06;

  typedef enum logic [1:0] {RX_HUNT, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {P_IDLE, P_ADDR, P_DATA, P_EXEC, P_RESP} parse_state_t;

  rx_state_t        rx_state;
  logic             rx_s1, rx_s2, rx_prev;
  logic [CNT_W-1:0] rx_div;
  logic [2:0]       rx_bit;
  logic [7:0]       rx_shift;
  logic             start_edge, stop_sample, byte_ok, byte_err;

  parse_state_t     state;
  logic             is_write;
  logic [1:0]       byte_cnt;
  logic [31:0]      addr, wdata;
  logic             req_q, we_q;
  logic [31:0]      addr_q;
  logic             timeout;

  logic             tx_active;
  logic [31:0]      tx_word;
  logic [1:0]       tx_idx, tx_last;
  logic [3:0]       tx_bit;
  logic [CNT_W-1:0] tx_div;
  logic [7:0]       tx_byte;
  logic             tx_finish;

  assign start_edge  = (rx_state == RX_HUNT) && rx_prev && !rx_s2;
  assign stop_sample = (rx_state == RX_STOP) && (rx_div == DIV_LAST);
  assign byte_ok     = stop_sample && rx_s2;
  assign byte_err    = stop_sample && !rx_s2;

  assign bus.mem_req  = req_q;
  assign bus.mem_we   = we_q;
  assign bus.mem_addr = addr_q;
  assign mem_data     = we_q ? wdata : {32{1'bz}};

  // Receiver: edge-triggered start hunt, mid-bit sampling, stop-bit validation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= RX_HUNT;
      rx_div   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      rx_s1   <= uart_rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
      case (rx_state)
        RX_HUNT: begin
          if (start_edge) begin
            rx_state <= RX_START;
            rx_div   <= '0;
          end
        end
        RX_START: begin
          if (rx_div == HALF_LAST) begin
            rx_div   <= '0;
            rx_bit   <= '0;
            rx_state <= rx_s2 ? RX_HUNT : RX_DATA;
          end else begin
            rx_div <= rx_div + CNT_W'(1);
          end
        end
        RX_DATA: begin
          if (rx_div == DIV_LAST) begin
            rx_div   <= '0;
            rx_shift <= {rx_s2, rx_shift[7:1]};
            rx_bit   <= rx_bit + 3'd1;
            if (rx_bit == 3'd7) rx_state <= RX_STOP;
          end else begin
            rx_div <= rx_div + CNT_W'(1);
          end
        end
        RX_STOP: begin
          if (rx_div == DIV_LAST) begin
            rx_div   <= '0;
            rx_state <= RX_HUNT;
          end else begin
            rx_div <= rx_div + CNT_W'(1);
          end
        end
        default: rx_state <= RX_HUNT;
      endcase
    end
  end

`ifdef UART_LOADER_TIMEOUT_EN
  localparam int TO_LIMIT = TIMEOUT_BITS * BAUD_DIV;
  localparam int TO_W     = $clog2(TO_LIMIT + 1);

  logic [TO_W-1:0] to_cnt;
  logic            parsing;

  assign parsing = (state == P_ADDR) || (state == P_DATA);
  assign timeout = parsing && (rx_state == RX_HUNT) && !start_edge &&
                   (to_cnt == TO_W'(TO_LIMIT - 1));

  // Only line-idle time between bytes counts; a new start bit rearms the window.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      to_cnt <= '0;
    end else if (!parsing || start_edge || timeout) begin
      to_cnt <= '0;
    end else if (rx_state == RX_HUNT) begin
      to_cnt <= to_cnt + TO_W'(1);
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // Command parser; bus outputs are single-cycle pulses issued on entry to EXEC.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= P_IDLE;
      is_write <= 1'b0;
      byte_cnt <= '0;
      addr     <= '0;
      wdata    <= '0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      busy     <= 1'b0;
    end else begin
      req_q  <= 1'b0;
      we_q   <= 1'b0;
      addr_q <= '0;
      case (state)
        P_IDLE: begin
          if (byte_ok && (rx_shift == CMD_WRITE || rx_shift == CMD_READ)) begin
            is_write <= (rx_shift == CMD_WRITE);
            byte_cnt <= '0;
            busy     <= 1'b1;
            state    <= P_ADDR;
          end
        end
        P_ADDR, P_DATA: begin
          if (byte_err || timeout) begin
            state    <= P_IDLE;
            busy     <= 1'b0;
            byte_cnt <= '0;
            addr     <= '0;
            wdata    <= '0;
          end else if (byte_ok) begin
            byte_cnt <= byte_cnt + 2'd1;
            if (state == P_ADDR) addr  <= {rx_shift, addr[31:8]};
            else                 wdata <= {rx_shift, wdata[31:8]};
            if (byte_cnt == 2'd3) begin
              if (state == P_ADDR && is_write) begin
                state <= P_DATA;
              end else begin
                state  <= P_EXEC;
                req_q  <= 1'b1;
                we_q   <= is_write;
                addr_q <= (state == P_ADDR) ? {rx_shift, addr[31:8]} : addr;
              end
            end
          end
        end
        P_EXEC: state <= P_RESP;
        P_RESP: begin
          if (tx_finish) begin
            state <= P_IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= P_IDLE;
      endcase
    end
  end

  assign tx_byte   = tx_word[{tx_idx, 3'b000} +: 8];
  assign tx_finish = tx_active && (tx_div == DIV_LAST) && (tx_bit == 4'd9) &&
                     (tx_idx == tx_last);

  // Transmitter: read data is captured off the bus at the end of the EXEC cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      uart_tx   <= 1'b1;
      tx_active <= 1'b0;
      tx_word   <= '0;
      tx_idx    <= '0;
      tx_last   <= '0;
      tx_bit    <= '0;
      tx_div    <= '0;
    end else if (state == P_EXEC) begin
      tx_active <= 1'b1;
      tx_word   <= is_write ? {24'd0, ACK_BYTE} : mem_data;
      tx_idx    <= '0;
      tx_last   <= is_write ? 2'd0 : 2'd3;
      tx_bit    <= '0;
      tx_div    <= '0;
      uart_tx   <= 1'b0;
    end else if (tx_active) begin
      if (tx_div == DIV_LAST) begin
        tx_div <= '0;
        if (tx_bit == 4'd9) begin
          tx_bit <= '0;
          if (tx_idx == tx_last) begin
            tx_active <= 1'b0;
            uart_tx   <= 1'b1;
          end else begin
            tx_idx  <= tx_idx + 2'd1;
            uart_tx <= 1'b0;
          end
        end else begin
          tx_bit  <= tx_bit + 4'd1;
          uart_tx <= (tx_bit == 4'd8) ? 1'b1 : tx_byte[tx_bit[2:0]];
        end
      end else begin
        tx_div <= tx_div + CNT_W'(1);
      end
    end
  end

endmodule
